// File: rtl/prog_loader.sv
// prog_loader
//   Receives a serial program image (MSB first, 16-bit fields) and writes it
//   into the mips_16 instruction memory while holding the core in reset.
//   Frame: header word N, then N data words, then checksum = XOR of the data.
//   A good checksum releases the core (done); anything else parks in err.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   reset      : asynchronous, active-low reset
//   start      : one-cycle pulse that begins or restarts a load
//   sin_valid  : qualifies sin_data this cycle
//   sin_data   : serial payload bit, MSB first
//   imem_we    : one-cycle instruction-memory write strobe
//   imem_addr  : instruction-memory write address (ADDR_W bits)
//   imem_wdata : instruction-memory write data (16 bits)
//   core_rst   : active-high reset for the core, low only in DONE
//   busy       : high while receiving header, data or checksum
//   done       : load finished with a matching checksum
//   err        : load rejected (bad header or bad checksum)
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sin_valid,
  input  logic              sin_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int MAX_WORDS = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_reg;
  logic [3:0]        bit_cnt_reg;
  logic [14:0]       shift_reg;      // only 15 bits kept: the 16th arrives live
  logic [ADDR_W:0]   word_cnt_reg;   // one bit wider so N = MAX_WORDS is countable
  logic [ADDR_W:0]   n_words_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       acc_reg;

  logic              in_frame;
  logic              take_bit;
  logic              word_done;
  logic [15:0]       word_val;
  logic [31:0]       hdr_ext;
  logic              hdr_ok;
  logic [ADDR_W:0]   word_cnt_inc;
  logic              last_word;

  always_comb begin
    in_frame     = (state_reg == S_HDR) || (state_reg == S_DATA) || (state_reg == S_CSUM);
    // start has priority: a bit arriving with start is dropped
    take_bit     = in_frame && sin_valid && !start;
    word_done    = take_bit && (bit_cnt_reg == 4'd15);
    word_val     = {shift_reg, sin_data};
    hdr_ext      = {16'h0000, word_val};
    hdr_ok       = (word_val != 16'h0000) && (hdr_ext <= 32'(MAX_WORDS));
    word_cnt_inc = word_cnt_reg + 1'b1;
    last_word    = (word_cnt_inc == n_words_reg);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      word_cnt_reg <= '0;
      n_words_reg  <= '0;
      addr_reg     <= '0;
      acc_reg      <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 16'h0000;
      core_rst     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      imem_we <= 1'b0;

      if (start) begin
        state_reg    <= S_HDR;
        bit_cnt_reg  <= '0;
        shift_reg    <= '0;
        word_cnt_reg <= '0;
        n_words_reg  <= '0;
        addr_reg     <= '0;
        acc_reg      <= '0;
        core_rst     <= 1'b1;
        busy         <= 1'b1;
        done         <= 1'b0;
        err          <= 1'b0;
      end else if (take_bit) begin
        shift_reg   <= word_val[14:0];
        bit_cnt_reg <= bit_cnt_reg + 4'd1;  // wraps to 0 after the 16th bit

        if (word_done) begin
          case (state_reg)
            S_HDR: begin
              if (!hdr_ok) begin
                state_reg <= S_ERR;
                err       <= 1'b1;
                busy      <= 1'b0;
              end else begin
                n_words_reg  <= (ADDR_W+1)'(word_val);
                word_cnt_reg <= '0;
                addr_reg     <= '0;
                state_reg    <= S_DATA;
              end
            end

            S_DATA: begin
              imem_we      <= 1'b1;
              imem_addr    <= addr_reg;
              imem_wdata   <= word_val;
              acc_reg      <= acc_reg ^ word_val;
              word_cnt_reg <= word_cnt_inc;
              if (last_word) begin
                // leave the address on the last slot instead of wrapping
                state_reg <= S_CSUM;
              end else begin
                addr_reg <= addr_reg + 1'b1;
              end
            end

            S_CSUM: begin
              busy <= 1'b0;
              if (word_val == acc_reg) begin
                state_reg <= S_DONE;
                done      <= 1'b1;
                core_rst  <= 1'b0;
              end else begin
                state_reg <= S_ERR;
                err       <= 1'b1;
              end
            end

            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule
